// File: rtl/enemy_ctrl.sv
// Enemy control: LFSR lane picker, combat FSM (move/wind-up/punch/stun/KO)
// and hit-point counter feeding the enemy datapath and VGA drawer.
module enemy_ctrl #(
  parameter logic [7:0] LFSR_SEED     = 8'hA5,
  parameter int         WINDUP_CYCLES = 25000000,
  parameter int         STUN_CYCLES   = 50000000,
  parameter int         HP_MAX        = 100,
  parameter int         HIT_DMG       = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       round_start,
  input  logic       move,
  input  logic       attack_req,
  input  logic       hit,
  input  logic [1:0] player_x,
  output logic [1:0] x_pos,
  output logic       speed,
  output logic       attack,
  output logic       telegraph,
  output logic       punch,
  output logic       player_hit,
  output logic [7:0] hp,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MOVE   = 3'd1,
    S_WINDUP = 3'd2,
    S_PUNCH  = 3'd3,
    S_STUN   = 3'd4,
    S_KO     = 3'd5
  } state_t;

  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [7:0]  SEED    = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [7:0]  HP_INIT = 8'(HP_MAX);
  localparam logic [7:0]  DMG     = 8'(HIT_DMG);
  localparam logic [7:0]  HP_HALF = 8'(HP_MAX / 2);
  localparam logic [7:0]  HP_QTR  = 8'(HP_MAX / 4);
  localparam logic [26:0] WIN_LD  = 27'(WINDUP_CYCLES - 1);
  localparam logic [26:0] STN_LD  = 27'(STUN_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [1:0]  x_q, x_d;
  logic [7:0]  hp_q, hp_d;
  logic [26:0] cnt_q, cnt_d;

  logic [7:0]  lfsr_nx;
  logic [7:0]  hp_hit;
  logic        hit_ok;

  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : 8'd0;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Rotating on a useless candidate guarantees the lane changes every step.
  function automatic logic [1:0] pick_lane(input logic [1:0] cand, input logic [1:0] cur);
    if (cand == 2'b00 || cand == cur)
      return (cur == 2'b11) ? 2'b01 : cur + 2'b01;
    return cand;
  endfunction

  assign lfsr_nx = lfsr_step(lfsr_q);
  assign hp_hit  = sat_sub(hp_q, DMG);
  assign hit_ok  = hit && (state_q == S_MOVE || state_q == S_WINDUP || state_q == S_PUNCH);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      x_q     <= 2'b10;
      hp_q    <= HP_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      x_q     <= x_d;
      hp_q    <= hp_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    x_d     = x_q;
    hp_d    = hp_q;
    cnt_d   = cnt_q;
    if (enable) begin
      if (hit_ok) hp_d = hp_hit;
      case (state_q)
        S_IDLE: begin
          x_d = 2'b10;
          if (round_start) state_d = S_MOVE;
        end
        S_MOVE: begin
          if (attack_req) begin
            state_d = S_WINDUP;
            cnt_d   = WIN_LD;
          end else if (move) begin
            lfsr_d = lfsr_nx;
            x_d    = pick_lane(lfsr_nx[1:0], x_q);
          end
        end
        S_WINDUP: begin
          if (hit) begin
            state_d = S_STUN;
            cnt_d   = STN_LD;
          end else if (cnt_q == '0) begin
            state_d = S_PUNCH;
          end else begin
            cnt_d = cnt_q - 27'd1;
          end
        end
        S_PUNCH: state_d = S_MOVE;
        S_STUN: begin
          if (cnt_q == '0) state_d = S_MOVE;
          else             cnt_d   = cnt_q - 27'd1;
        end
        S_KO: begin
          if (round_start) begin
            state_d = S_MOVE;
            hp_d    = HP_INIT;
            x_d     = 2'b10;
          end
        end
        default: state_d = S_IDLE;
      endcase
      // A lethal hit wins over every other transition, including stun.
      if (hit_ok && hp_hit == 8'd0) state_d = S_KO;
    end
  end

  assign x_pos      = x_q;
  assign hp         = hp_q;
  assign state_out  = state_q;
  assign telegraph  = (state_q == S_WINDUP);
  assign punch      = enable && (state_q == S_PUNCH);
  assign player_hit = punch && (player_x == x_q);
  assign speed      = (hp_q < HP_HALF);
  assign attack     = (hp_q < HP_QTR);

endmodule

// File: tb/tb_enemy_ctrl.sv
// Self-checking bench for enemy_ctrl: directed scenarios plus a randomized run
// against a behavioural model of the enemy rules.
module tb_enemy_ctrl;
  localparam int WC  = 4;
  localparam int SC  = 3;
  localparam int HPM = 100;
  localparam int DMG = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       round_start = 1'b0;
  logic       move = 1'b0;
  logic       attack_req = 1'b0;
  logic       hit = 1'b0;
  logic [1:0] player_x = 2'b10;
  logic [1:0] x_pos;
  logic       speed, attack, telegraph, punch, player_hit;
  logic [7:0] hp;
  logic [2:0] state_out;

  int checks = 0;
  int errors = 0;

  // Model: phase 0..5, remaining cycles in the current timed phase.
  int         m_state, m_hp, m_rem;
  logic [7:0] m_lfsr;
  logic [1:0] m_x;

  enemy_ctrl #(
    .LFSR_SEED(8'hA5), .WINDUP_CYCLES(WC), .STUN_CYCLES(SC),
    .HP_MAX(HPM), .HIT_DMG(DMG)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .round_start(round_start),
    .move(move), .attack_req(attack_req), .hit(hit), .player_x(player_x),
    .x_pos(x_pos), .speed(speed), .attack(attack), .telegraph(telegraph),
    .punch(punch), .player_hit(player_hit), .hp(hp), .state_out(state_out)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_state = 0; m_hp = HPM; m_rem = 0; m_lfsr = 8'hA5; m_x = 2'b10;
  endtask

  function automatic logic [1:0] rotate(input logic [1:0] x);
    return (x == 2'b11) ? 2'b01 : x + 2'b01;
  endfunction

  task automatic model_clock(input logic en, input logic rs, input logic mv,
                             input logic ar, input logic h);
    int nxt;
    bit took;
    logic [1:0] cand;
    if (!en) return;
    took = h && (m_state >= 1 && m_state <= 3);
    nxt = m_state;
    if (took) m_hp = (m_hp > DMG) ? m_hp - DMG : 0;
    case (m_state)
      0: if (rs) nxt = 1;
      1: begin
        if (ar) begin
          nxt = 2; m_rem = WC;
        end else if (mv) begin
          m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
          cand = m_lfsr[1:0];
          m_x = (cand == 2'b00 || cand == m_x) ? rotate(m_x) : cand;
        end
      end
      2: begin
        if (h) begin
          nxt = 4; m_rem = SC;
        end else begin
          m_rem--;
          if (m_rem == 0) nxt = 3;
        end
      end
      3: nxt = 1;
      4: begin
        m_rem--;
        if (m_rem == 0) nxt = 1;
      end
      5: if (rs) begin nxt = 1; m_hp = HPM; m_x = 2'b10; end
      default: nxt = 0;
    endcase
    if (took && m_hp == 0) nxt = 5;
    m_state = nxt;
  endtask

  task automatic tick(input logic rs, input logic mv, input logic ar, input logic h);
    round_start = rs; move = mv; attack_req = ar; hit = h;
    model_clock(enable, rs, mv, ar, h);
    @(posedge clock); #1;
    round_start = 1'b0; move = 1'b0; attack_req = 1'b0; hit = 1'b0;
  endtask

  task automatic do_reset();
    enable = 1'b1; round_start = 1'b0; move = 1'b0; attack_req = 1'b0; hit = 1'b0;
    reset = 1'b1;
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({state_out, x_pos, hp} !== {3'd0, 2'b10, 8'd100}) begin
      errors++; $display("FAIL reset_regs got %h/%b/%0d want 0/10/100", state_out, x_pos, hp);
    end
    checks++;
    if ({telegraph, punch, player_hit, speed, attack} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b want 00000", {telegraph, punch, player_hit, speed, attack});
    end
    tick(0, 1, 1, 1);
    checks++;
    if ({state_out, x_pos, hp} !== {3'd0, 2'b10, 8'd100}) begin
      errors++; $display("FAIL idle_ignore got %h/%b/%0d want 0/10/100", state_out, x_pos, hp);
    end
  endtask

  task automatic test_lfsr_lanes();
    do_reset();
    tick(1, 0, 0, 0);
    checks++;
    if ({state_out, x_pos} !== {3'd1, 2'b10}) begin
      errors++; $display("FAIL round_start got %0d/%b want 1/10", state_out, x_pos);
    end
    tick(0, 1, 0, 0);
    checks++;
    if (x_pos !== 2'b11) begin
      errors++; $display("FAIL lane_step1 got %b want 11", x_pos);
    end
    tick(0, 1, 0, 0);
    checks++;
    if (x_pos !== 2'b01 || x_pos !== m_x) begin
      errors++; $display("FAIL lane_step2 got %b want 01 (model %b)", x_pos, m_x);
    end
  endtask

  task automatic run_attack(input logic [1:0] px, input logic want_hit);
    player_x = px;
    tick(0, 0, 1, 0);
    for (int i = 0; i < WC; i++) begin
      checks++;
      if ({state_out, telegraph, punch} !== {3'd2, 1'b1, 1'b0}) begin
        errors++; $display("FAIL windup_c%0d got st=%0d tel=%b pun=%b want 2/1/0", i, state_out, telegraph, punch);
      end
      tick(0, 0, 0, 0);
    end
    checks++;
    if ({state_out, telegraph, punch, player_hit} !== {3'd3, 1'b0, 1'b1, want_hit}) begin
      errors++; $display("FAIL punch_px%b got st=%0d tel=%b pun=%b ph=%b want 3/0/1/%b",
                         px, state_out, telegraph, punch, player_hit, want_hit);
    end
    tick(0, 0, 0, 0);
    checks++;
    if ({state_out, punch} !== {3'd1, 1'b0}) begin
      errors++; $display("FAIL after_punch got st=%0d pun=%b want 1/0", state_out, punch);
    end
  endtask

  task automatic test_attack();
    do_reset();
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0);
    checks++;
    if (x_pos !== 2'b11) begin
      errors++; $display("FAIL attack_setup got %b want 11", x_pos);
    end
    run_attack(2'b11, 1'b1);
    run_attack(2'b01, 1'b0);
  endtask

  task automatic test_simultaneous();
    do_reset();
    tick(1, 0, 0, 0);
    tick(0, 1, 1, 0);
    checks++;
    if ({state_out, x_pos} !== {3'd2, 2'b10}) begin
      errors++; $display("FAIL simul_strobe got %0d/%b want 2/10", state_out, x_pos);
    end
    repeat (WC + 1) tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    checks++;
    if (x_pos !== 2'b11 || x_pos !== m_x) begin
      errors++; $display("FAIL simul_lfsr_held got %b want 11 (model %b)", x_pos, m_x);
    end
  endtask

  task automatic test_counterpunch();
    do_reset();
    player_x = 2'b10;
    tick(1, 0, 0, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    checks++;
    if ({state_out, telegraph, hp} !== {3'd4, 1'b0, 8'd90}) begin
      errors++; $display("FAIL counterpunch got st=%0d tel=%b hp=%0d want 4/0/90", state_out, telegraph, hp);
    end
    for (int i = 0; i < SC; i++) begin
      checks++;
      if ({state_out, punch} !== {3'd4, 1'b0}) begin
        errors++; $display("FAIL stun_c%0d got st=%0d pun=%b want 4/0", i, state_out, punch);
      end
      tick(0, 1, 1, 1);
    end
    checks++;
    if ({state_out, hp, x_pos} !== {3'd1, 8'd90, 2'b10}) begin
      errors++; $display("FAIL stun_exit got %0d/%0d/%b want 1/90/10", state_out, hp, x_pos);
    end
  endtask

  task automatic test_thresholds_ko();
    int eh;
    do_reset();
    tick(1, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      tick(0, 0, 0, 1);
      eh = HPM - DMG * i;
      checks++;
      if ({hp, speed, attack} !== {8'(eh), 1'(eh < HPM / 2), 1'(eh < HPM / 4)}) begin
        errors++; $display("FAIL hp_hit%0d got hp=%0d sp=%b at=%b want %0d/%b/%b",
                           i, hp, speed, attack, eh, eh < HPM / 2, eh < HPM / 4);
      end
    end
    checks++;
    if (state_out !== 3'd5) begin
      errors++; $display("FAIL ko_enter got %0d want 5", state_out);
    end
    tick(0, 1, 1, 1);
    checks++;
    if ({state_out, hp} !== {3'd5, 8'd0}) begin
      errors++; $display("FAIL ko_sticky got %0d/%0d want 5/0", state_out, hp);
    end
    tick(1, 0, 0, 0);
    checks++;
    if ({state_out, hp, x_pos, speed, attack} !== {3'd1, 8'd100, 2'b10, 2'b00}) begin
      errors++; $display("FAIL ko_restart got %0d/%0d/%b/%b%b want 1/100/10/00",
                         state_out, hp, x_pos, speed, attack);
    end
  endtask

  task automatic test_freeze_reset();
    do_reset();
    player_x = 2'b10;
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 1);
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1, 1, 1, 1);
      checks++;
      if ({state_out, hp, telegraph, punch} !== {3'd2, 8'd90, 1'b1, 1'b0}) begin
        errors++; $display("FAIL freeze_c%0d got st=%0d hp=%0d tel=%b pun=%b want 2/90/1/0",
                           i, state_out, hp, telegraph, punch);
      end
    end
    enable = 1'b1;
    repeat (WC - 1) tick(0, 0, 0, 0);
    checks++;
    if ({state_out, punch, player_hit} !== {3'd3, 1'b1, 1'b1}) begin
      errors++; $display("FAIL freeze_resume got st=%0d pun=%b ph=%b want 3/1/1", state_out, punch, player_hit);
    end
    enable = 1'b0;
    #1;
    checks++;
    if ({punch, player_hit} !== 2'b00) begin
      errors++; $display("FAIL punch_gated got %b want 00", {punch, player_hit});
    end
    tick(0, 0, 0, 0);
    enable = 1'b1;
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({state_out, telegraph, hp, punch, x_pos} !== {3'd0, 1'b0, 8'd100, 1'b0, 2'b10}) begin
      errors++; $display("FAIL async_reset got st=%0d tel=%b hp=%0d pun=%b x=%b want 0/0/100/0/10",
                         state_out, telegraph, hp, punch, x_pos);
    end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic rs, mv, ar, h;
    logic ep, eph;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      enable   = ($urandom_range(0, 9) != 0);
      player_x = 2'($urandom_range(1, 3));
      rs = ($urandom_range(0, 19) == 0);
      mv = ($urandom_range(0, 2) == 0);
      ar = ($urandom_range(0, 7) == 0);
      h  = ($urandom_range(0, 5) == 0);
      tick(rs, mv, ar, h);
      checks++;
      if ({state_out, x_pos, hp, telegraph, speed, attack} !==
          {3'(m_state), m_x, 8'(m_hp), 1'(m_state == 2), 1'(m_hp < HPM / 2), 1'(m_hp < HPM / 4)}) begin
        errors++; $display("FAIL rand_regs n=%0d got st=%0d x=%b hp=%0d tel=%b sp=%b at=%b want st=%0d x=%b hp=%0d",
                           n, state_out, x_pos, hp, telegraph, speed, attack, m_state, m_x, m_hp);
      end
      ep  = enable && (m_state == 3);
      eph = ep && (player_x == m_x);
      checks++;
      if ({punch, player_hit} !== {ep, eph}) begin
        errors++; $display("FAIL rand_punch n=%0d got %b%b want %b%b", n, punch, player_hit, ep, eph);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lfsr_lanes();
    test_attack();
    test_simultaneous();
    test_counterpunch();
    test_thresholds_ko();
    test_freeze_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/enemy_ctrl.md
Name: enemy_ctrl

Overview:
- Control end of the enemy datapath interface: consumes the datapath's `move` strobe and attack request, and produces the `x_pos`, `speed` and `attack` inputs the datapath consumes.
- Contains an 8-bit LFSR position picker, the enemy combat FSM (move / wind-up / punch / stun / KO) and the enemy hit-point counter.
- Sits between enemy_datapath and the top-level game FSM; the VGA drawer reads `telegraph` and `state_out`.

Parameters:
- LFSR_SEED, 8'hA5, LFSR reset value; a value of 0 is replaced by 8'h01.
- WINDUP_CYCLES, 25000000, length of the wind-up phase in clocks (0.5 s at 50 MHz).
- STUN_CYCLES, 50000000, length of the stun phase in clocks.
- HP_MAX, 100, starting hit points; range 1..255.
- HIT_DMG, 10, hit points removed per landed player punch.

Ports:
- clock  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high; all state cleared immediately
- enable  in  1  high = block advances; low = freeze all state, `punch` forced 0
- round_start  in  1  one-cycle pulse from the game FSM
- move  in  1  one-cycle strobe from enemy_datapath
- attack_req  in  1  one-cycle strobe from enemy_datapath attack logic
- hit  in  1  one-cycle pulse: player punch landed on the enemy
- player_x  in  2  player lane: 01, 10 or 11
- x_pos  out  2  enemy lane to the datapath; always 01, 10 or 11
- speed  out  1  to the datapath; 1 = fast
- attack  out  1  to the datapath; 1 = aggressive
- telegraph  out  1  high during wind-up
- punch  out  1  one-cycle pulse: enemy punch resolves
- player_hit  out  1  one-cycle pulse: enemy punch connected
- hp  out  8  current enemy hit points
- state_out  out  3  encoding IDLE=0, MOVE=1, WINDUP=2, PUNCH=3, STUN=4, KO=5

Behaviour:
- Reset values:
  - state IDLE, lfsr=seed, x_pos=2'b10, hp=HP_MAX, counter=0.
  - punch, player_hit, telegraph all 0.
- `speed` and `attack` are combinational from the hp register:
  - speed = (hp < HP_MAX/2).
  - attack = (hp < HP_MAX/4).
  - Integer division; both are 0 at reset.
- `enable` low: no register changes and every input pulse is ignored; punch and player_hit are 0.
- LFSR step:
  - fb = l[7]^l[5]^l[4]^l[3]; l <= {l[6:0], fb}.
  - The candidate lane is the new l[1:0].
  - If the candidate is 00 or equals the current x_pos, x_pos rotates instead: 01->10, 10->11, 11->01.
  - Otherwise x_pos takes the candidate.
  - x_pos therefore changes on every step. The LFSR steps only on an accepted `move`.
- IDLE:
  - x_pos is held at 10.
  - round_start -> MOVE.
- MOVE:
  - attack_req -> WINDUP and load counter=WINDUP_CYCLES-1. attack_req has priority: a `move` in the same cycle is dropped and x_pos holds.
  - Else `move` -> one LFSR step.
- WINDUP:
  - telegraph=1; counter decrements each cycle.
  - At counter==0 -> PUNCH.
  - `move` and attack_req are ignored.
- PUNCH: occupies exactly one cycle.
  - punch=1, and player_hit=(player_x==x_pos), sampled that cycle.
  - Next state MOVE.
- `hit` handling:
  - Accepted in MOVE, WINDUP and PUNCH: hp <= hp - HIT_DMG, saturating at 0.
  - A hit in WINDUP also -> STUN with counter=STUN_CYCLES-1; telegraph drops the next cycle.
  - A hit in PUNCH does not cancel the punch.
  - Ignored in IDLE, STUN and KO.
- STUN:
  - Counter decrements; at 0 -> MOVE.
  - The LFSR is frozen.
- KO:
  - Any accepted hit that leaves hp==0 -> KO on the next clock; this overrides the STUN transition.
  - KO is sticky. round_start -> MOVE with hp=HP_MAX and x_pos=10; the LFSR is not reseeded.
- round_start in MOVE, WINDUP, PUNCH or STUN is ignored.
- Asynchronous reset mid-operation (including mid-WINDUP): all outputs return to their reset values within the same cycle; no punch is emitted.
- Counter is 27 bits wide. WINDUP_CYCLES=1 or STUN_CYCLES=1 gives a one-cycle phase.

Test Plan (bench uses WINDUP_CYCLES=4, STUN_CYCLES=3, HP_MAX=100, HIT_DMG=10):
- LFSR and lane sequence: reset, round_start, then two `move` pulses -> lfsr A5->4A gives x_pos 10->11 (candidate 10 equals current, so rotate); then 4A->95 gives x_pos 01.
- Attack with player in lane: player_x=11, x_pos=11, attack_req in MOVE -> telegraph high exactly 4 cycles, then punch=1 and player_hit=1 for one cycle, then state MOVE. Repeat with player_x=01 -> player_hit=0.
- Simultaneous strobes: `move` and attack_req in the same cycle -> state WINDUP, x_pos and lfsr unchanged.
- Counterpunch: hit during the 2nd wind-up cycle -> hp=90, state STUN for 3 cycles, no punch pulse, then MOVE.
- Thresholds and KO: six hits in MOVE -> hp=40, speed=1, attack=0. Four more hits -> hp=0, state KO, later hits ignored. round_start -> hp=100, x_pos=10, state MOVE.
- Freeze and async reset: enable=0 during WINDUP -> counter holds, pulses are ignored. Assert reset between clock edges mid-WINDUP -> state IDLE, telegraph=0, hp=100 immediately.
